// File: rtl/imem_access_arbiter.sv
// Arbitrates a single-port synchronous-read instruction memory between the fetch unit
// and the loader/debug port, with address checking and a one-cycle response stage.
module imem_access_arbiter #(
    parameter int          MEM_SIZE   = 128,
    parameter int          MAX_WAIT   = 4,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013,
    localparam int         ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_lock,
    input  logic                  f_req_valid,
    output logic                  f_req_ready,
    input  logic [31:0]           f_req_addr,
    output logic                  f_rsp_valid,
    output logic [31:0]           f_rsp_data,
    output logic                  f_rsp_err,
    input  logic                  l_req_valid,
    output logic                  l_req_ready,
    input  logic [31:0]           l_req_addr,
    input  logic                  l_req_we,
    input  logic [31:0]           l_req_wdata,
    output logic                  l_rsp_valid,
    output logic [31:0]           l_rsp_data,
    output logic                  l_rsp_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int              SW         = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0]   MAX_WAIT_C = SW'(MAX_WAIT);
    localparam logic [SW-1:0]   STARVE_ONE = SW'(1);
    localparam logic [29:0]     MEM_SIZE_C = 30'(MEM_SIZE);

    logic [SW-1:0] starve_q, starve_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_owner_q, rsp_owner_d;
    logic          rsp_we_q, rsp_we_d;
    logic          rsp_err_q, rsp_err_d;

    logic          f_cand_s, l_cand_s, f_grant_s, l_grant_s, grant_s;
    logic [31:0]   sel_addr_s;
    logic [29:0]   word_idx_s;
    logic          addr_err_s;
    logic [31:0]   rsp_data_s;

    // Arbitration: loader preferred, fetch forced through once it has waited MAX_WAIT cycles.
    // Grants are held off while rst_n is low so the memory strobe stays quiet in reset.
    always_comb begin
        f_cand_s  = f_req_valid && !load_lock && rst_n;
        l_cand_s  = l_req_valid && rst_n;
        l_grant_s = 1'b0;
        f_grant_s = 1'b0;
        if (l_cand_s && f_cand_s) begin
            f_grant_s = (starve_q == MAX_WAIT_C);
            l_grant_s = !f_grant_s;
        end else begin
            f_grant_s = f_cand_s;
            l_grant_s = l_cand_s;
        end
        grant_s     = f_grant_s || l_grant_s;
        f_req_ready = f_grant_s;
        l_req_ready = l_grant_s;
    end

    // Fetch starvation counter next state.
    always_comb begin
        starve_d = starve_q;
        if (load_lock || !f_req_valid || f_grant_s) begin
            starve_d = '0;
        end else if (starve_q != MAX_WAIT_C) begin
            starve_d = starve_q + STARVE_ONE;
        end else begin
            starve_d = starve_q;
        end
    end

    // Decode of the granted address and memory drive; errored accesses never reach the array.
    always_comb begin
        sel_addr_s = l_grant_s ? l_req_addr : f_req_addr;
        word_idx_s = sel_addr_s[31:2];
        addr_err_s = (sel_addr_s[1:0] != 2'b00) || (word_idx_s >= MEM_SIZE_C);
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'h0000_0000;
        if (grant_s && !addr_err_s) begin
            mem_en   = 1'b1;
            mem_addr = word_idx_s[ADDR_WIDTH-1:0];
            mem_we   = l_grant_s && l_req_we;
            if (l_grant_s && l_req_we) begin
                mem_wdata = l_req_wdata;
            end else begin
                mem_wdata = 32'h0000_0000;
            end
        end else begin
            mem_en = 1'b0;
        end
    end

    // Response stage next state: who was granted and what kind of access it was.
    always_comb begin
        rsp_valid_d = grant_s;
        rsp_owner_d = l_grant_s;
        rsp_we_d    = l_grant_s && l_req_we;
        rsp_err_d   = grant_s && addr_err_s;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Response data select and steering to the owning requester; read data passes straight through.
    always_comb begin
        if (rsp_err_q) begin
            rsp_data_s = rsp_we_q ? 32'h0000_0000 : NOP_WORD;
        end else if (rsp_we_q) begin
            rsp_data_s = 32'h0000_0000;
        end else begin
            rsp_data_s = mem_rdata;
        end
        f_rsp_valid = 1'b0;
        f_rsp_data  = 32'h0000_0000;
        f_rsp_err   = 1'b0;
        l_rsp_valid = 1'b0;
        l_rsp_data  = 32'h0000_0000;
        l_rsp_err   = 1'b0;
        if (rsp_valid_q && rsp_owner_q) begin
            l_rsp_valid = 1'b1;
            l_rsp_data  = rsp_data_s;
            l_rsp_err   = rsp_err_q;
        end else if (rsp_valid_q) begin
            f_rsp_valid = 1'b1;
            f_rsp_data  = rsp_data_s;
            f_rsp_err   = rsp_err_q;
        end else begin
            f_rsp_valid = 1'b0;
        end
    end

endmodule
